pipe_stage_buf: RTL
===================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the payload width in bits (legal range 1..256).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of payload entries (power of two, 2..16).
REQ-003 The block SHALL have parameter BUBBLE, default {WIDTH{1'b0}}, meaning the value driven on data_o when the block is empty.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port valid_i, input, 1 bit: the upstream stage offers data_i.
REQ-007 The block SHALL have port data_i, input, WIDTH bits: the upstream payload.
REQ-008 The block SHALL have port ready_o, output, 1 bit: the block accepts a payload this cycle.
REQ-009 The block SHALL have port valid_o, output, 1 bit: data_o holds a valid payload.
REQ-010 The block SHALL have port data_o, output, WIDTH bits: the head payload, or BUBBLE when empty.
REQ-011 The block SHALL have port ready_i, input, 1 bit: the downstream stage accepts data_o this cycle.
REQ-012 The block SHALL have port flush_i, input, 1 bit: discard all held and incoming payloads.
REQ-013 The block SHALL have port count_o, output, $clog2(DEPTH)+1 bits: the number of entries currently held.

Function
REQ-014 A push SHALL occur on a rising edge where valid_i=1, ready_o=1, flush_i=0 and rst_n=1.
REQ-015 A pop SHALL occur on a rising edge where valid_o=1, ready_i=1, flush_i=0 and rst_n=1.
REQ-016 ready_o SHALL equal (count_o < DEPTH), derived combinationally from registered state only, with no path from ready_i.
REQ-017 valid_o SHALL equal (count_o != 0); data_o SHALL equal the oldest held entry when valid_o=1, and BUBBLE otherwise.
REQ-018 Latency: a payload pushed into an empty block SHALL appear on data_o with valid_o=1 in the cycle after the push edge; the block SHALL have no combinational data_i-to-data_o path.
REQ-019 Ordering SHALL be strict FIFO; no payload SHALL be duplicated, reordered or dropped, except by flush_i or reset.
REQ-020 Simultaneous push and pop SHALL leave count_o unchanged and SHALL sustain one transfer per cycle at any occupancy from 1 to DEPTH-1.
REQ-021 When full (count_o=DEPTH), ready_o SHALL be 0 and no push SHALL occur even if a pop happens on the same edge; ready_o SHALL rise in the following cycle.
REQ-022 When empty, a pop SHALL be impossible; ready_i SHALL be ignored and data_o SHALL hold BUBBLE.
REQ-023 The read and write pointers SHALL each be $clog2(DEPTH) bits and SHALL wrap modulo DEPTH with no lost entry at wrap-around.
REQ-024 count_o SHALL increment by 1 on push-only, decrement by 1 on pop-only, and otherwise hold, never exceeding DEPTH or underflowing 0.
REQ-025 flush_i=1 SHALL, at the edge, set count_o=0 and both pointers to 0; it SHALL override any same-cycle push or pop, and the flushed payload SHALL never appear on data_o.
REQ-026 Storage contents SHALL NOT be cleared by flush_i or reset; only pointers and count SHALL be reset, and data_o SHALL be masked to BUBBLE while empty.

Reset
REQ-027 With rst_n=0 at an edge, count_o, the read pointer and the write pointer SHALL all become 0, taking priority over flush_i, push and pop.
REQ-028 After reset, outputs SHALL be valid_o=0, ready_o=1, data_o=BUBBLE and count_o=0.
REQ-029 Reset asserted mid-transfer SHALL discard all held entries; the first push after reset release SHALL be the first payload output.

Verification
REQ-030 Reset then idle -> valid_o=0, ready_o=1, data_o=0, count_o=0.
REQ-031 DEPTH=2: push 0xA1, 0xB2 with ready_i=0 -> count_o=2 and ready_o=0; a third offer of 0xC3 is not accepted; then ready_i=1 -> outputs 0xA1, then 0xB2, then 0xC3 after re-acceptance.
REQ-032 Continuous valid_i=1 and ready_i=1 with payloads 1..20 -> outputs 1..20 in order, one per cycle after a 1-cycle fill, with pointers wrapping 10 times.
REQ-033 Hold 2 entries and assert flush_i together with a push of 0x55 -> next cycle count_o=0, valid_o=0, data_o=BUBBLE, and 0x55 is never output.
REQ-034 Assert rst_n=0 with flush_i=1 and count_o=1 -> next cycle count_o=0 and ready_o=1; push 0x7E -> 0x7E is output first.
REQ-035 Random valid_i/ready_i traffic for 10k cycles against a reference queue model -> zero mismatches, and count_o never exceeds DEPTH.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - Registered FIFO pipeline buffer with flush and occupancy count
module pipe_stage_buf #(
    parameter int               WIDTH  = 32,
    parameter int               DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       valid_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    input  logic                       ready_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    // Handshakes depend only on registered occupancy, so ready_o never sees ready_i.
    assign ready_o = (count_q < DEPTH_C);
    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : BUBBLE;
    assign count_o = count_q;

    assign push = valid_i & ready_o & ~flush_i;
    assign pop  = valid_o & ready_i & ~flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is never cleared; emptiness is tracked solely by count_q.
    always_ff @(posedge clk_i) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule
